// File: rtl/jelly_video_gate_sequencer_pkg.sv
// Shared state encoding and status widths for the video gate sequencer.
package jelly_video_gate_sequencer_pkg;

   localparam int STATUS_STATE_WIDTH = 2;

   // Encoding 2'd3 is unused; the sequencer recovers from it to IDLE.
   typedef enum logic [STATUS_STATE_WIDTH-1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/jelly_video_gate_sequencer.sv
// Video gate sequencer: opens the downstream video gate for a bounded (or
// continuous) number of frames, optionally passing only 1 of every N frames.
// Optional feature: define JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN to enable
// frame decimation; without it param_decimate is ignored and every frame of
// a run is passed.
module jelly_video_gate_sequencer
   import jelly_video_gate_sequencer_pkg::*;
#(
   parameter int FRAME_WIDTH = 16,
   parameter int DECIM_WIDTH = 8
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cke,
   input  logic                          ctl_start,
   input  logic                          ctl_stop,
   input  logic [FRAME_WIDTH-1:0]        param_frames,
   input  logic [DECIM_WIDTH-1:0]        param_decimate,
   input  logic                          param_skip_idle,
   input  logic                          mon_frame_start,
   input  logic                          gate_busy,
   output logic                          gate_enable,
   output logic                          gate_skip,
   output logic [STATUS_STATE_WIDTH-1:0] status_state,
   output logic [FRAME_WIDTH-1:0]        status_frame_count,
   output logic                          irq_done
);

   localparam logic [FRAME_WIDTH-1:0] COUNT_ZERO = {FRAME_WIDTH{1'b0}};
   localparam logic [FRAME_WIDTH-1:0] COUNT_ONE  = {{(FRAME_WIDTH-1){1'b0}}, 1'b1};

   state_e                  state_q, state_d;
   logic                    gate_enable_q, gate_enable_d;
   logic                    gate_skip_q, gate_skip_d;
   logic                    irq_done_q, irq_done_d;
   logic [FRAME_WIDTH-1:0]  count_q, count_d;
   logic [FRAME_WIDTH-1:0]  frames_q, frames_d;
   logic [FRAME_WIDTH-1:0]  count_inc_s;
   logic                    limit_s;
   logic                    enable_next_s;

   // A frame that was passed bumps the counter; reaching a nonzero limit ends the run.
   assign count_inc_s = count_q + COUNT_ONE;
   assign limit_s     = mon_frame_start & gate_enable_q & (frames_q != COUNT_ZERO)
                        & (count_inc_s == frames_q);

`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
   localparam logic [DECIM_WIDTH-1:0] PHASE_ZERO = {DECIM_WIDTH{1'b0}};
   localparam logic [DECIM_WIDTH-1:0] PHASE_ONE  = {{(DECIM_WIDTH-1){1'b0}}, 1'b1};

   logic [DECIM_WIDTH-1:0]  decim_q, decim_d;
   logic [DECIM_WIDTH-1:0]  phase_q, phase_d;
   logic [DECIM_WIDTH-1:0]  phase_next_s;

   // Phase counts frames modulo (decimate+1); the frame at phase 0 is passed.
   assign phase_next_s  = (phase_q == decim_q) ? PHASE_ZERO : (phase_q + PHASE_ONE);
   assign enable_next_s = (phase_next_s == PHASE_ZERO);
`else
   logic unused_decimate_s;

   // Without decimation every frame of a run is passed.
   assign enable_next_s     = 1'b1;
   assign unused_decimate_s = ^param_decimate;
`endif

   // Next-state, gate control and counter update for the run sequencer.
   always_comb begin
      state_d       = state_q;
      gate_enable_d = gate_enable_q;
      count_d       = count_q;
      frames_d      = frames_q;
      irq_done_d    = 1'b0;
`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
      decim_d       = decim_q;
      phase_d       = phase_q;
`endif
      case (state_q)
         ST_IDLE: begin
            gate_enable_d = 1'b0;
            if (ctl_start && !ctl_stop) begin
               state_d       = ST_RUN;
               gate_enable_d = 1'b1;
               count_d       = COUNT_ZERO;
               frames_d      = param_frames;
`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
               decim_d       = param_decimate;
               phase_d       = PHASE_ZERO;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (mon_frame_start) begin
               if (gate_enable_q) begin
                  count_d = count_inc_s;
               end else begin
                  count_d = count_q;
               end
`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
               phase_d = phase_next_s;
`endif
               gate_enable_d = enable_next_s;
            end else begin
               gate_enable_d = gate_enable_q;
            end
            // Stop overrides the frame-start gate decision, but the count still lands.
            if (ctl_stop || limit_s) begin
               gate_enable_d = 1'b0;
               state_d       = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            gate_enable_d = 1'b0;
            if (!gate_busy && !mon_frame_start) begin
               state_d    = ST_IDLE;
               irq_done_d = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            gate_enable_d = 1'b0;
         end
      endcase
      gate_skip_d = (state_d == ST_IDLE) ? param_skip_idle : 1'b1;
   end

   // State and output registers; advance only on clock-enabled edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         gate_enable_q <= 1'b0;
         gate_skip_q   <= 1'b0;
         irq_done_q    <= 1'b0;
         count_q       <= COUNT_ZERO;
         frames_q      <= COUNT_ZERO;
`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
         decim_q       <= PHASE_ZERO;
         phase_q       <= PHASE_ZERO;
`endif
      end else if (cke) begin
         state_q       <= state_d;
         gate_enable_q <= gate_enable_d;
         gate_skip_q   <= gate_skip_d;
         irq_done_q    <= irq_done_d;
         count_q       <= count_d;
         frames_q      <= frames_d;
`ifdef JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN
         decim_q       <= decim_d;
         phase_q       <= phase_d;
`endif
      end
   end

   assign gate_enable        = gate_enable_q;
   assign gate_skip          = gate_skip_q;
   assign status_state       = state_q;
   assign status_frame_count = count_q;
   assign irq_done           = irq_done_q;

endmodule

// File: doc/jelly_video_gate_sequencer.md
JELLY_VIDEO_GATE_SEQUENCER -- requirements
Module: jelly_video_gate_sequencer

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 16, width of frame limit and frame counter.
REQ-002 SHALL have parameter DECIM_WIDTH, default 8, width of decimation ratio.
REQ-003 SHALL have ports (clock and reset first):
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- cke  input  1  clock enable; state holds when 0.
- ctl_start  input  1  start pulse.
- ctl_stop  input  1  stop pulse.
- param_frames  input  FRAME_WIDTH  frames to pass; 0 = continuous.
- param_decimate  input  DECIM_WIDTH  pass 1 of every param_decimate+1 frames.
- param_skip_idle  input  1  gate skip value while IDLE.
- mon_frame_start  input  1  frame-start beat accepted at gate input (tuser[0] & tvalid & tready).
- gate_busy  input  1  busy from the video gate.
- gate_enable  output  1  enable to the video gate.
- gate_skip  output  1  skip to the video gate.
- status_state  output  2  current state.
- status_frame_count  output  FRAME_WIDTH  passed frames this run.
- irq_done  output  1  one-cycle pulse on run completion.

Function
REQ-004 SHALL implement states IDLE=0, RUN=1, DRAIN=2; encoding 3 unused, recovers to IDLE.
REQ-005 All register updates SHALL occur only on clk edges with cke=1.
REQ-006 IDLE: gate_enable=0, gate_skip=param_skip_idle; ctl_start=1 and ctl_stop=0 -> RUN, latching param_frames and param_decimate, clearing frame counter and decimation phase, gate_enable=1 next cycle.
REQ-007 RUN and DRAIN: gate_skip SHALL be 1 so dropped frames are discarded, not stalled.
REQ-008 RUN, on mon_frame_start: if gate_enable=1, frame counter +1; phase advances modulo latched decimate+1; gate_enable next = (new phase == 0).
REQ-009 RUN: if latched frames != 0 and the increment makes counter equal latched frames -> gate_enable=0, go to DRAIN.
REQ-010 RUN: ctl_stop=1 -> gate_enable=0, go to DRAIN, overriding any same-cycle frame-start decision; the counter update from that frame start still applies.
REQ-011 Continuous mode (latched frames = 0): counter SHALL wrap from all-ones to 0; no DRAIN without ctl_stop.
REQ-012 DRAIN: gate_enable=0; when gate_busy=0 and mon_frame_start=0 -> IDLE with irq_done=1 for exactly one cycle.
REQ-013 ctl_start outside IDLE, and ctl_stop in IDLE, SHALL be ignored; start and stop together in IDLE -> stay IDLE.
REQ-014 gate_enable SHALL be registered; latency from mon_frame_start to updated gate_enable is 1 cycle; frames of at least 2 beats are supported.
REQ-015 status_frame_count SHALL hold its value in IDLE until the next start.

Reset
REQ-016 reset=1 SHALL asynchronously force IDLE, gate_enable=0, gate_skip=0, counter=0, phase=0, irq_done=0, status_state=0, latched params=0, regardless of cke.
REQ-017 Reset mid-RUN SHALL produce no irq_done; after release, gate_skip follows param_skip_idle from the first cke cycle.

Configuration
REQ-018 Macro JELLY_VIDEO_GATE_SEQUENCER_DECIMATE_EN defined: decimation per REQ-008.
REQ-019 Macro undefined: param_decimate port retained but ignored, no phase register, gate_enable=1 for every RUN frame.

Structure
REQ-020 Package jelly_video_gate_sequencer_pkg SHALL hold the state enum/constants and the status_state width constant.
REQ-021 Single module, no sub-module; counters and FSM inline.

Verification
REQ-022 start, frames=3, decimate=0, 5 frame starts -> frames 1-3 enabled, DRAIN after 3rd, count=3, irq_done once after gate_busy falls.
REQ-023 macro on, frames=2, decimate=2, 6 frame starts -> enabled on frames 1 and 4, count=2, DRAIN after frame 4.
REQ-024 macro off, same stimulus as REQ-023 -> frames 1 and 2 enabled, DRAIN after frame 2.
REQ-025 frames=0, ctl_stop after 10 frames -> count=10, gate_enable=0 one cycle after stop, irq_done after busy falls.
REQ-026 reset asserted in RUN with count=2 -> gate_enable=0 and state IDLE immediately without clk edge, no irq_done.
REQ-027 start+stop same cycle in IDLE, cke=0 during start pulse -> state stays IDLE, gate_enable stays 0.
